// File: rtl/collision_checker.sv
// collision_checker: sequential head-collision checker for the snake core.
// On every accepted move step the body is scanned one segment per cycle for
// a self-hit, the head is compared with the apple, and the outcome is
// reported as a sticky bad collision or a good-collision request held until
// the apple generator acknowledges. A saturating score counts apples eaten.
// Optional feature: define WALL_COLL_EN to make border cells count as a hit.
module collision_checker #(
  parameter int MAX_LENGTH = 50,
  parameter int LEN_W      = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step,
  input  logic [7:0]                  head,
  input  logic [7:0]                  apple_cord,
  input  logic [MAX_LENGTH-1:0][7:0]  body,
  input  logic [LEN_W-1:0]            length,
  input  logic                        apple_ack,
  output logic                        good_coll,
  output logic                        bad_coll,
  output logic                        busy,
  output logic                        step_ovr,
  output logic [7:0]                  score
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    RESOLVE = 3'd2,
    GOOD    = 3'd3,
    DEAD    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LENGTH);

  state_t           state;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       head_q;
  logic [7:0]       apple_q;
  logic             hit;
  logic [LEN_W-1:0] len_clamp;
  logic             wall_hit;
  logic             seg_match;

  // Length is clamped so the scan never indexes past the last body slot.
  assign len_clamp = (length > MAX_LEN_C) ? MAX_LEN_C : length;

  // Live compare of the currently addressed body segment against the head.
  assign seg_match = (body[idx] == head_q);

`ifdef WALL_COLL_EN
  // Border cells (x or y equal to 0 or 15) are treated as a wall hit.
  assign wall_hit = (head_q[7:4] == 4'd0) || (head_q[7:4] == 4'd15) ||
                    (head_q[3:0] == 4'd0) || (head_q[3:0] == 4'd15);
`else
  // Border cells are legal playfield positions.
  assign wall_hit = 1'b0;
`endif

  // Checker FSM with registered Moore outputs updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      head_q    <= 8'd0;
      apple_q   <= 8'd0;
      hit       <= 1'b0;
      good_coll <= 1'b0;
      bad_coll  <= 1'b0;
      busy      <= 1'b0;
      step_ovr  <= 1'b0;
      score     <= 8'd0;
    end else begin
      // A step that cannot be accepted is recorded as an overrun.
      if (step && (state != IDLE)) begin
        step_ovr <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (step) begin
            head_q  <= head;
            apple_q <= apple_cord;
            len_q   <= len_clamp;
            hit     <= 1'b0;
            busy    <= 1'b1;
            if (len_clamp <= LEN_W'(1)) begin
              state <= RESOLVE;
            end else begin
              state <= SCAN;
              idx   <= LEN_W'(1);
            end
          end else begin
            busy <= 1'b0;
          end
        end

        SCAN: begin
          if (seg_match) begin
            hit   <= 1'b1;
            state <= RESOLVE;
          end else if (idx == (len_q - LEN_W'(1))) begin
            state <= RESOLVE;
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end

        RESOLVE: begin
          if (hit || wall_hit) begin
            state    <= DEAD;
            bad_coll <= 1'b1;
          end else if (head_q == apple_q) begin
            state     <= GOOD;
            good_coll <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        GOOD: begin
          if (apple_ack) begin
            state     <= IDLE;
            good_coll <= 1'b0;
            busy      <= 1'b0;
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
          end
        end

        DEAD: begin
          state <= DEAD;
        end

        default: begin
          state     <= IDLE;
          good_coll <= 1'b0;
          bad_coll  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_checker.sv
// Self-checking bench for collision_checker: directed scenarios with literal
// expectations plus a cycle-level outcome model compared every cycle.
module tb_collision_checker;

  localparam int ML = 50;

  logic             clk;
  logic             reset;
  logic             step;
  logic [7:0]       head;
  logic [7:0]       apple_cord;
  logic [ML-1:0][7:0] body;
  logic [5:0]       length;
  logic             apple_ack;
  logic             good_coll;
  logic             bad_coll;
  logic             busy;
  logic             step_ovr;
  logic [7:0]       score;

  int n_cmp;
  int n_bad;
  bit chk_en;

  collision_checker #(.MAX_LENGTH(ML), .LEN_W(6)) dut (
    .clk(clk), .reset(reset), .step(step), .head(head),
    .apple_cord(apple_cord), .body(body), .length(length),
    .apple_ack(apple_ack), .good_coll(good_coll), .bad_coll(bad_coll),
    .busy(busy), .step_ovr(step_ovr), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 checking (m_remain cycles left), 2 good, 3 dead.
  int       m_mode;
  int       m_remain;
  int       m_out;
  int       m_score;
  bit       m_ovr;

  function automatic bit on_wall(input logic [7:0] c);
`ifdef WALL_COLL_EN
    return (c[7:4] == 4'd0) || (c[7:4] == 4'd15) || (c[3:0] == 4'd0) || (c[3:0] == 4'd15);
`else
    return 1'b0;
`endif
  endfunction

  // Outcome model: decides result and duration at step time.
  always @(posedge clk) begin : model
    int L;
    int n;
    bit hitf;
    if (reset) begin
      m_mode <= 0; m_remain <= 0; m_out <= 0; m_score <= 0; m_ovr <= 1'b0;
    end else begin
      if (step && m_mode != 0) m_ovr <= 1'b1;
      case (m_mode)
        0: if (step) begin
          L = (int'(length) > ML) ? ML : int'(length);
          n = 0;
          hitf = 1'b0;
          if (L >= 2) begin
            n = L - 1;
            for (int k = 1; k < L; k++) begin
              if (!hitf && body[k] == head) begin
                hitf = 1'b1;
                n = k;
              end
            end
          end
          if (on_wall(head)) hitf = 1'b1;
          m_out    <= hitf ? 3 : ((head == apple_cord) ? 2 : 0);
          m_remain <= n + 1;
          m_mode   <= 1;
        end
        1: begin
          if (m_remain == 1) m_mode <= m_out;
          else m_remain <= m_remain - 1;
        end
        2: if (apple_ack) begin
          m_mode <= 0;
          if (m_score < 255) m_score <= m_score + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", int'(busy), int'(m_mode != 0));
      cmp("good_coll", int'(good_coll), int'(m_mode == 2));
      cmp("bad_coll", int'(bad_coll), int'(m_mode == 3));
      cmp("step_ovr", int'(step_ovr), int'(m_ovr));
      cmp("score", int'(score), m_score);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a one-cycle step; returns in cycle 1 relative to the step.
  task automatic do_step(input logic [7:0] h, input logic [7:0] a, input logic [5:0] l);
    head = h; apple_cord = a; length = l; step = 1'b1;
    wait_n(1);
    step = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    wait_n(1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    reset = 1'b1; step = 1'b0; apple_ack = 1'b0;
    head = 8'h00; apple_cord = 8'h00; length = 6'd0;
    for (int i = 0; i < ML; i++) body[i] = 8'h80 + 8'(i);
    wait_n(2);
    chk_en = 1'b1;
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_score", int'(score), 0);
    reset = 1'b0;
    wait_n(1);

    // Eat: L=4, head=apple=55, no self-hit.
    body[0] = 8'h55; body[1] = 8'h54; body[2] = 8'h53; body[3] = 8'h52;
    do_step(8'h55, 8'h55, 6'd4);
    cmp("eat_busy_c1", int'(busy), 1);
    wait_n(3);
    cmp("eat_busy_c4", int'(busy), 1);
    cmp("eat_good_c4", int'(good_coll), 0);
    wait_n(1);
    cmp("eat_good_c5", int'(good_coll), 1);
    wait_n(2);
    apple_ack = 1'b1;
    wait_n(1);
    apple_ack = 1'b0;
    cmp("eat_good_c8", int'(good_coll), 0);
    cmp("eat_score", int'(score), 1);

    // Ack while idle is ignored.
    apple_ack = 1'b1;
    wait_n(1);
    apple_ack = 1'b0;
    wait_n(1);
    cmp("idle_ack_score", int'(score), 1);

    // Step together with ack in GOOD: ack taken, step flagged.
    do_step(8'h77, 8'h77, 6'd1);
    wait_n(1);
    apple_ack = 1'b1; step = 1'b1;
    wait_n(1);
    apple_ack = 1'b0; step = 1'b0;
    cmp("stepack_score", int'(score), 2);
    cmp("stepack_ovr", int'(step_ovr), 1);
    cmp("stepack_busy", int'(busy), 0);
    pulse_reset();

    // Overrun during SCAN and length clamped to 50.
    do_step(8'h66, 8'h67, 6'd60);
    wait_n(9);
    step = 1'b1;
    wait_n(1);
    step = 1'b0;
    cmp("ovr_set", int'(step_ovr), 1);
    wait_n(39);
    cmp("len_busy_c50", int'(busy), 1);
    wait_n(1);
    cmp("len_idle_c51", int'(busy), 0);
    cmp("len_good_c51", int'(good_coll), 0);

    // 256 eats saturate the score.
    for (int e = 0; e < 256; e++) begin
      do_step(8'h77, 8'h77, 6'd1);
      wait_n(1);
      apple_ack = 1'b1;
      wait_n(1);
      apple_ack = 1'b0;
    end
    cmp("score_sat", int'(score), 255);

    // Reset while in GOOD.
    do_step(8'h77, 8'h77, 6'd1);
    wait_n(1);
    cmp("good_before_rst", int'(good_coll), 1);
    reset = 1'b1;
    wait_n(1);
    cmp("rst_good", int'(good_coll), 0);
    cmp("rst_busy_mid", int'(busy), 0);
    cmp("rst_score_mid", int'(score), 0);
    reset = 1'b0;
    wait_n(1);

    // Wall: head on x=0 border, single segment.
    do_step(8'h0A, 8'h77, 6'd1);
    wait_n(1);
`ifdef WALL_COLL_EN
    cmp("wall_bad", int'(bad_coll), 1);
`else
    cmp("wall_busy", int'(busy), 0);
    cmp("wall_bad", int'(bad_coll), 0);
`endif
    pulse_reset();

    // Hit plus apple: bad wins.
    body[2] = 8'h44;
    do_step(8'h44, 8'h44, 6'd3);
    wait_n(3);
    cmp("ha_bad_c4", int'(bad_coll), 1);
    cmp("ha_good_c4", int'(good_coll), 0);
    cmp("ha_score", int'(score), 0);
    pulse_reset();

    // Self-hit at idx 3, then later steps/acks change nothing.
    body[3] = 8'h33;
    do_step(8'h33, 8'h00, 6'd5);
    wait_n(3);
    cmp("sh_bad_c4", int'(bad_coll), 0);
    cmp("sh_busy_c4", int'(busy), 1);
    wait_n(1);
    cmp("sh_bad_c5", int'(bad_coll), 1);
    step = 1'b1; apple_ack = 1'b1;
    wait_n(1);
    step = 1'b0; apple_ack = 1'b0;
    wait_n(3);
    cmp("sh_bad_hold", int'(bad_coll), 1);
    cmp("sh_ovr", int'(step_ovr), 1);
    cmp("sh_good", int'(good_coll), 0);
    cmp("sh_score", int'(score), 0);

    wait_n(1);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
